// File: rtl/hc_tx_arb_pkg.sv
// Shared types and helpers for the host-controller TX port arbiter.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package hc_tx_arb_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        ST_START    = 2'd0,
        ST_WAIT_REQ = 2'd1,
        ST_GRANTED  = 2'd2
    } arb_state_e;

    // Bits needed to index v items, never less than one bit
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/hc_tx_arb_pick.sv
// Combinational winner select over an eligible request vector (req & ~mask).
// Latency: zero cycles, purely combinational.
// Backpressure: none; vld_o low when no eligible request, idx_o is then 0.
// Ports: req_i/mask_i per-channel request and exclusion mask, ptr_i last granted
//        channel, rr_mode_i selects round-robin, vld_o/idx_o winner.
module hc_tx_arb_pick
    import hc_tx_arb_pkg::*;
#(
    parameter int NUM_CH = 3,
    parameter int SEL_W  = clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [NUM_CH-1:0] mask_i,
    input  logic [SEL_W-1:0]  ptr_i,
    input  logic              rr_mode_i,
    output logic              vld_o,
    output logic [SEL_W-1:0]  idx_o
);

    logic [NUM_CH-1:0] elig;
    logic [SEL_W-1:0]  scan_idx;
    logic              found;

    always_comb begin
        elig     = req_i & ~mask_i;
        vld_o    = |elig;
        idx_o    = '0;
        scan_idx = '0;
        found    = 1'b0;
        if (rr_mode_i) begin
            // Scan starts one past the last winner and wraps, so the last
            // winner is considered only when nobody else is asking.
            for (int k = 1; k <= NUM_CH; k++) begin
                scan_idx = SEL_W'((int'(ptr_i) + k) % NUM_CH);
                if (!found && elig[scan_idx]) begin
                    found = 1'b1;
                    idx_o = scan_idx;
                end
            end
        end else begin
            // Walk downwards so the lowest set index is the last to write.
            for (int i = NUM_CH - 1; i >= 0; i--) begin
                if (elig[i]) begin
                    idx_o = SEL_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/hc_tx_port_arb_n.sv
// N-channel arbiter/mux for the HC TX port; one requester owns the port until it drops req.
// Latency: req sampled in WAIT_REQ -> grant after that edge; release -> grant low after that edge,
//          at least one idle cycle before the next grant. Port mux is combinational from grant regs.
// Backpressure: no pre-emption; others wait while a grant is held. Optional macro
//          HC_TX_ARB_TIMEOUT_EN revokes a grant after MAX_HOLD cycles and masks that channel
//          until it drops req; without it grants are held indefinitely and timeoutErr is 0.
// Ports: clk/rst (sync, active high); chReq/chWEn/chData/chCntl per-channel inputs (channel i
//        at [i*W +: W]); chGnt one-hot grant; HCTxPort* muxed port; arbBusy; timeoutErr pulse.
module hc_tx_port_arb_n
    import hc_tx_arb_pkg::*;
#(
    parameter int NUM_CH      = 3,
    parameter int DATA_W      = 8,
    parameter int CNTL_W      = 8,
    parameter int ROUND_ROBIN = 0,
    parameter int MAX_HOLD    = 4096
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        chReq,
    input  logic [NUM_CH-1:0]        chWEn,
    input  logic [NUM_CH*DATA_W-1:0] chData,
    input  logic [NUM_CH*CNTL_W-1:0] chCntl,
    output logic [NUM_CH-1:0]        chGnt,
    output logic                     HCTxPortWEnable,
    output logic [DATA_W-1:0]        HCTxPortData,
    output logic [CNTL_W-1:0]        HCTxPortCntl,
    output logic                     arbBusy,
    output logic                     timeoutErr
);

    localparam int SEL_W = clog2(NUM_CH);

    if ((NUM_CH < 2) || (NUM_CH > 8) || (MAX_HOLD < 2)) begin : g_bad_cfg
        $error("hc_tx_port_arb_n: NUM_CH must be 2..8 and MAX_HOLD at least 2");
    end

    arb_state_e        state_q, state_d;
    logic [NUM_CH-1:0] gnt_q, gnt_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [SEL_W-1:0]  ptr_q, ptr_d;
    logic [NUM_CH-1:0] pick_mask;
    logic              pick_vld;
    logic [SEL_W-1:0]  pick_idx;
    logic              sel_req;

`ifdef HC_TX_ARB_TIMEOUT_EN
    localparam int HOLD_W = clog2(MAX_HOLD);

    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [NUM_CH-1:0] mask_q, mask_d;
    logic              terr_q, terr_d;

    assign pick_mask  = mask_q;
    assign timeoutErr = terr_q;
`else
    assign pick_mask  = '0;
    assign timeoutErr = 1'b0;
`endif

    hc_tx_arb_pick #(
        .NUM_CH (NUM_CH),
        .SEL_W  (SEL_W)
    ) u_pick (
        .req_i     (chReq),
        .mask_i    (pick_mask),
        .ptr_i     (ptr_q),
        .rr_mode_i (ROUND_ROBIN != 0),
        .vld_o     (pick_vld),
        .idx_o     (pick_idx)
    );

    // Current request level of the channel that holds the grant
    always_comb begin
        sel_req = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (sel_q == SEL_W'(i)) begin
                sel_req = chReq[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
`ifdef HC_TX_ARB_TIMEOUT_EN
        hold_d  = hold_q;
        terr_d  = 1'b0;
        // A masked channel becomes eligible again once its req is seen low.
        mask_d  = mask_q & chReq;
`endif
        case (state_q)
            ST_START: begin
                state_d = ST_WAIT_REQ;
            end
            ST_WAIT_REQ: begin
                if (pick_vld) begin
                    state_d = ST_GRANTED;
                    gnt_d   = NUM_CH'(1) << pick_idx;
                    sel_d   = pick_idx;
                    ptr_d   = pick_idx;
`ifdef HC_TX_ARB_TIMEOUT_EN
                    hold_d  = '0;
`endif
                end
            end
            ST_GRANTED: begin
                // A voluntary release takes precedence over a timeout on the same edge.
                if (!sel_req) begin
                    state_d = ST_WAIT_REQ;
                    gnt_d   = '0;
                end
`ifdef HC_TX_ARB_TIMEOUT_EN
                else if (hold_q == HOLD_W'(MAX_HOLD - 1)) begin
                    state_d = ST_WAIT_REQ;
                    gnt_d   = '0;
                    terr_d  = 1'b1;
                    mask_d  = mask_d | gnt_q;
                end else begin
                    hold_d  = hold_q + 1'b1;
                end
`endif
            end
            default: begin
                state_d = ST_START;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_START;
            gnt_q   <= '0;
            sel_q   <= '0;
            ptr_q   <= SEL_W'(NUM_CH - 1);
`ifdef HC_TX_ARB_TIMEOUT_EN
            hold_q  <= '0;
            mask_q  <= '0;
            terr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
`ifdef HC_TX_ARB_TIMEOUT_EN
            hold_q  <= hold_d;
            mask_q  <= mask_d;
            terr_q  <= terr_d;
`endif
        end
    end

    assign chGnt   = gnt_q;
    assign arbBusy = |gnt_q;

    // Only the granted channel reaches the port; idle port is all zero.
    always_comb begin
        HCTxPortWEnable = 1'b0;
        HCTxPortData    = '0;
        HCTxPortCntl    = '0;
        if (arbBusy) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (sel_q == SEL_W'(i)) begin
                    HCTxPortWEnable = chWEn[i];
                    HCTxPortData    = chData[i*DATA_W +: DATA_W];
                    HCTxPortCntl    = chCntl[i*CNTL_W +: CNTL_W];
                end
            end
        end
    end

endmodule

// File: tb/tb_hc_tx_port_arb_n.sv
// Scoreboard bench: a fixed-priority and a round-robin instance share stimulus;
// a reference model pushes expected port state per cycle, a monitor pops and compares.
// Timeout scenarios are modelled when HC_TX_ARB_TIMEOUT_EN is defined (MAX_HOLD=16).
module tb_hc_tx_port_arb_n;

    localparam int N  = 3;
    localparam int DW = 8;
    localparam int CW = 8;
    localparam int MH = 16;

    typedef struct packed {
        logic [N-1:0]  gnt;
        logic          wen;
        logic [DW-1:0] data;
        logic [CW-1:0] cntl;
        logic          busy;
        logic          terr;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    ch_req;
    logic [N-1:0]    ch_wen;
    logic [N*DW-1:0] ch_data;
    logic [N*CW-1:0] ch_cntl;

    logic [N-1:0]  gnt_o   [2];
    logic          wen_o   [2];
    logic [DW-1:0] data_o  [2];
    logic [CW-1:0] cntl_o  [2];
    logic          busy_o  [2];
    logic          terr_o  [2];

    int total = 0;
    int bad   = 0;

    exp_t q_fp[$];
    exp_t q_rr[$];

    // Reference model state, index 0 = fixed priority, 1 = round robin.
    // phase: 0 = just out of reset, 1 = waiting for requests, 2 = owner holds the port
    int           phase [2];
    int           owner [2];
    int           last  [2];
    int           held  [2];
    logic [N-1:0] excl  [2];
    logic         tpulse[2];

    always #5 clk = ~clk;

    hc_tx_port_arb_n #(
        .NUM_CH(N), .DATA_W(DW), .CNTL_W(CW), .ROUND_ROBIN(0), .MAX_HOLD(MH)
    ) dut_fp (
        .clk(clk), .rst(rst), .chReq(ch_req), .chWEn(ch_wen), .chData(ch_data), .chCntl(ch_cntl),
        .chGnt(gnt_o[0]), .HCTxPortWEnable(wen_o[0]), .HCTxPortData(data_o[0]),
        .HCTxPortCntl(cntl_o[0]), .arbBusy(busy_o[0]), .timeoutErr(terr_o[0])
    );

    hc_tx_port_arb_n #(
        .NUM_CH(N), .DATA_W(DW), .CNTL_W(CW), .ROUND_ROBIN(1), .MAX_HOLD(MH)
    ) dut_rr (
        .clk(clk), .rst(rst), .chReq(ch_req), .chWEn(ch_wen), .chData(ch_data), .chCntl(ch_cntl),
        .chGnt(gnt_o[1]), .HCTxPortWEnable(wen_o[1]), .HCTxPortData(data_o[1]),
        .HCTxPortCntl(cntl_o[1]), .arbBusy(busy_o[1]), .timeoutErr(terr_o[1])
    );

    function automatic int pick(input int m, input logic [N-1:0] elig);
        if (m == 0) begin
            for (int i = 0; i < N; i++) if (elig[i]) return i;
        end else begin
            for (int k = 1; k <= N; k++) if (elig[(last[m] + k) % N]) return (last[m] + k) % N;
        end
        return 0;
    endfunction

    // Advance model m across one clock edge using the inputs now applied.
    task automatic model_step(input int m, output exp_t e);
        logic [N-1:0] elig;
        if (rst) begin
            phase[m] = 0; owner[m] = 0; last[m] = N - 1; held[m] = 0;
            excl[m] = '0; tpulse[m] = 1'b0;
        end else begin
            tpulse[m] = 1'b0;
            elig = ch_req & ~excl[m];
            excl[m] = excl[m] & ch_req;
            if (phase[m] == 0) begin
                phase[m] = 1;
            end else if (phase[m] == 1) begin
                if (elig != 0) begin
                    owner[m] = pick(m, elig);
                    last[m]  = owner[m];
                    held[m]  = 0;
                    phase[m] = 2;
                end
            end else begin
                if (!ch_req[owner[m]]) begin
                    phase[m] = 1;
`ifdef HC_TX_ARB_TIMEOUT_EN
                end else if (held[m] == MH - 1) begin
                    phase[m] = 1;
                    tpulse[m] = 1'b1;
                    excl[m][owner[m]] = 1'b1;
`endif
                end else begin
                    held[m] = held[m] + 1;
                end
            end
        end
        e.busy = (phase[m] == 2);
        e.gnt  = e.busy ? (N'(1) << owner[m]) : '0;
        e.wen  = e.busy ? ch_wen[owner[m]] : 1'b0;
        e.data = e.busy ? ch_data[owner[m]*DW +: DW] : '0;
        e.cntl = e.busy ? ch_cntl[owner[m]*CW +: CW] : '0;
        e.terr = tpulse[m];
    endtask

    task automatic cyc(input logic r, input logic [N-1:0] req, input logic [N-1:0] wen,
                       input logic [N*DW-1:0] d, input logic [N*CW-1:0] c);
        exp_t e;
        @(negedge clk);
        rst = r; ch_req = req; ch_wen = wen; ch_data = d; ch_cntl = c;
        model_step(0, e); q_fp.push_back(e);
        model_step(1, e); q_rr.push_back(e);
    endtask

    task automatic rcyc(input logic r, input logic [N-1:0] req, input int n);
        repeat (n) cyc(r, req, N'($urandom()), (N*DW)'($urandom()), (N*CW)'($urandom()));
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, req);
        end
    endtask

    task automatic compare(input int m, input exp_t e);
        string p;
        p = (m == 0) ? "fp" : "rr";
        chk({p, "_gnt"},  32'(gnt_o[m]),  32'(e.gnt));
        chk({p, "_wen"},  32'(wen_o[m]),  32'(e.wen));
        chk({p, "_data"}, 32'(data_o[m]), 32'(e.data));
        chk({p, "_cntl"}, 32'(cntl_o[m]), 32'(e.cntl));
        chk({p, "_busy"}, 32'(busy_o[m]), 32'(e.busy));
        chk({p, "_terr"}, 32'(terr_o[m]), 32'(e.terr));
    endtask

    // Monitor: after every edge, compare whatever the model predicted for it.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q_fp.size() > 0) begin e = q_fp.pop_front(); compare(0, e); end
            if (q_rr.size() > 0) begin e = q_rr.pop_front(); compare(1, e); end
        end
    end

    initial begin
        #400000;
        bad++;
        $display("FAIL watchdog: run did not complete within time limit");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        logic [N-1:0] rq;
        rst = 1'b1; ch_req = '0; ch_wen = '0; ch_data = '0; ch_cntl = '0;

        // Reset and idle with every channel driving the port inputs
        repeat (2) cyc(1'b1, 3'b000, 3'b111, {3{8'hAA}}, '0);
        repeat (4) cyc(1'b0, 3'b000, 3'b111, {3{8'hAA}}, {3{8'h0F}});

        // Fixed priority: ch1 keeps the port while ch0 arrives, ch0 follows
        rcyc(1'b0, 3'b110, 4);
        rcyc(1'b0, 3'b111, 4);
        rcyc(1'b0, 3'b101, 4);
        rcyc(1'b0, 3'b000, 3);

        // Round robin: all request, current owner drops for one cycle every 4
        rcyc(1'b1, 3'b000, 1);
        for (int k = 0; k < 5; k++) begin
            rcyc(1'b0, 3'b111, 4);
            rcyc(1'b0, 3'b111 & ~(N'(1) << owner[1]), 1);
        end
        rcyc(1'b0, 3'b000, 3);

        // Mux: ch2 owns the port, ch0 write enable must not leak through
        repeat (5) cyc(1'b0, 3'b100, 3'b101, {8'h5A, 8'h11, 8'h22}, {8'h03, 8'h44, 8'h55});
        repeat (2) cyc(1'b0, 3'b000, 3'b101, {8'h5A, 8'h11, 8'h22}, {8'h03, 8'h44, 8'h55});

        // Reset during a ch1 grant with its req held, then re-grant
        rcyc(1'b0, 3'b010, 4);
        rcyc(1'b1, 3'b010, 1);
        rcyc(1'b0, 3'b010, 4);

        // Release and a new request on the same edge; drop and re-raise
        rcyc(1'b0, 3'b001, 3);
        rcyc(1'b0, 3'b001, 1);
        rcyc(1'b0, 3'b100, 3);
        rcyc(1'b0, 3'b000, 1);
        rcyc(1'b0, 3'b100, 3);
        rcyc(1'b0, 3'b000, 2);

        // Long hold by ch0 with ch1 waiting (revoked when the timeout build is used)
        rcyc(1'b0, 3'b001, 10);
        rcyc(1'b0, 3'b011, 30);
        rcyc(1'b0, 3'b010, 3);
        rcyc(1'b0, 3'b011, 4);
        rcyc(1'b0, 3'b000, 3);

        // Random traffic with occasional reset
        rq = '0;
        for (int c = 0; c < 2500; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 7) == 0) rq[i] = ~rq[i];
            end
            rcyc(($urandom_range(0, 299) == 0), rq, 1);
        end
        rcyc(1'b0, 3'b000, 2);

        repeat (3) @(posedge clk);
        #2;
        chk("fp_queue_drained", 32'(q_fp.size()), 32'd0);
        chk("rr_queue_drained", 32'(q_rr.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
